// File: rtl/codec_volume_writer.sv
// rtl/codec_volume_writer.sv - I2C writer for the codec headphone-out volume register
//
// Purpose:
//   Takes volume requests (volume2DAC qualified by the volchange strobe) and writes
//   them to the codec over I2C as a 3-byte write: {DEV_ADDR,W}, {REG_ADDR,BOTH_CH},
//   {ZERO_CROSS,volume}. Requests that arrive while a write is in flight are
//   coalesced; only the newest value is written once the bus is free again.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   volume2DAC  in   [6:0] requested codec volume code
//   volchange   in   one-cycle strobe, volume2DAC is valid
//   sdat_in     in   SDAT pin readback, sampled during ACK slots
//   i2c_sclk    out  SCL, push-pull, idle high
//   sdat_oe     out  1 = pull SDAT low, 0 = release
//   busy        out  high from START until STOP has completed
//   ack_error   out  sticky NACK flag, cleared by reset or a fully acknowledged write

module codec_volume_writer #(
  parameter int unsigned CLK_DIV    = 125,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter logic [6:0]  REG_ADDR   = 7'h02,
  parameter logic        BOTH_CH    = 1'b1,
  parameter logic        ZERO_CROSS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] volume2DAC,
  input  logic       volchange,
  input  logic       sdat_in,
  output logic       i2c_sclk,
  output logic       sdat_oe,
  output logic       busy,
  output logic       ack_error
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;
  logic [1:0]       phase_q;
  logic [2:0]       bit_q;
  logic [1:0]       byte_q;
  logic [23:0]      shift_q;
  logic [6:0]       vol_q;
  logic             pending_q;
  logic             nack_q;
  logic             sclk_q;
  logic             oe_q;
  logic             busy_q;
  logic             ack_err_q;

  // Quarter-period divider. Held at zero while idle so the first slot of a frame
  // is a full CLK_DIV cycles long.
  assign tick = (state_q != S_IDLE) && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if ((state_q == S_IDLE) || tick) begin
      div_d = '0;
    end
  end

  // Every slot's line levels are set on the tick that ends the previous slot, so
  // phase_q names the slot currently on the wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      shift_q   <= 24'd0;
      vol_q     <= 7'd0;
      pending_q <= 1'b0;
      nack_q    <= 1'b0;
      sclk_q    <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      div_q <= div_d;

      // Last request wins; pending only drops on a cycle spent in IDLE, which is
      // exactly when the latched value gets loaded into a frame.
      if (volchange) begin
        vol_q     <= volume2DAC;
        pending_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
        pending_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            shift_q <= {DEV_ADDR, 1'b0, REG_ADDR, BOTH_CH, ZERO_CROSS, vol_q};
            busy_q  <= 1'b1;
            sclk_q  <= 1'b1;
            oe_q    <= 1'b1;   // START: SDA falls while SCL is high
            phase_q <= 2'd0;
            byte_q  <= 2'd0;
            bit_q   <= 3'd0;
            nack_q  <= 1'b0;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            if (phase_q == 2'd0) begin
              sclk_q  <= 1'b0;
              phase_q <= 2'd1;
            end else begin
              oe_q    <= ~shift_q[23];
              phase_q <= 2'd0;
              state_q <= S_BIT;
            end
          end
        end

        S_BIT: begin
          if (tick) begin
            case (phase_q)
              2'd0: begin
                sclk_q  <= 1'b1;
                phase_q <= 2'd1;
              end
              2'd1: begin
                phase_q <= 2'd2;
              end
              2'd2: begin
                sclk_q  <= 1'b0;
                phase_q <= 2'd3;
              end
              default: begin
                shift_q <= {shift_q[22:0], 1'b0};
                phase_q <= 2'd0;
                if (bit_q == 3'd7) begin
                  bit_q   <= 3'd0;
                  oe_q    <= 1'b0;   // release SDA for the slave's ACK
                  state_q <= S_ACK;
                end else begin
                  bit_q <= bit_q + 3'd1;
                  oe_q  <= ~shift_q[22];
                end
              end
            endcase
          end
        end

        S_ACK: begin
          if (tick) begin
            case (phase_q)
              2'd0: begin
                sclk_q  <= 1'b1;
                phase_q <= 2'd1;
              end
              2'd1: begin
                phase_q <= 2'd2;
              end
              2'd2: begin
                // Sampled while SCL is still high on the pin.
                nack_q  <= sdat_in;
                if (sdat_in) begin
                  ack_err_q <= 1'b1;
                end
                sclk_q  <= 1'b0;
                phase_q <= 2'd3;
              end
              default: begin
                phase_q <= 2'd0;
                if (nack_q || (byte_q == 2'd2)) begin
                  oe_q    <= 1'b1;   // SDA low with SCL low, ready for STOP
                  state_q <= S_STOP;
                  if (!nack_q) begin
                    ack_err_q <= 1'b0;
                  end
                end else begin
                  byte_q  <= byte_q + 2'd1;
                  oe_q    <= ~shift_q[23];
                  state_q <= S_BIT;
                end
              end
            endcase
          end
        end

        S_STOP: begin
          if (tick) begin
            case (phase_q)
              2'd0: begin
                sclk_q  <= 1'b1;
                phase_q <= 2'd1;
              end
              2'd1: begin
                oe_q    <= 1'b0;   // STOP: SDA rises while SCL is high
                phase_q <= 2'd2;
              end
              default: begin
                busy_q  <= 1'b0;
                phase_q <= 2'd0;
                state_q <= S_IDLE;
              end
            endcase
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign i2c_sclk  = sclk_q;
  assign sdat_oe   = oe_q;
  assign busy      = busy_q;
  assign ack_error = ack_err_q;

endmodule

// File: tb/tb_codec_volume_writer.sv
// tb/tb_codec_volume_writer.sv - bench for codec_volume_writer with bus slave and line-level model

module tb_codec_volume_writer;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic [6:0] volume2DAC;
  logic       volchange;
  logic       sdat_in;
  logic       i2c_sclk;
  logic       sdat_oe;
  logic       busy;
  logic       ack_error;

  codec_volume_writer #(.CLK_DIV(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .volume2DAC (volume2DAC),
    .volchange  (volchange),
    .sdat_in    (sdat_in),
    .i2c_sclk   (i2c_sclk),
    .sdat_oe    (sdat_oe),
    .busy       (busy),
    .ack_error  (ack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame = list of quarter-period slots derived from the bytes.
  int nack_sel = 3;          // byte index the slave will NACK (3 = none)
  logic        m_in_frame;
  logic        m_pending;
  logic [6:0]  m_vol;
  logic [23:0] m_frame;
  int          m_cyc;
  int          m_len;
  int          m_nb;
  int          m_nack = 3;
  logic        m_ack_err;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  // Returns {scl, sda_oe} for slot s of a frame carrying nb bytes.
  function automatic logic [1:0] exp_lines(int s, logic [23:0] fr, int nb);
    int body, b, r, q;
    logic scl, oe;
    body = 36 * nb;
    if (s == 0) return 2'b11;
    if (s == 1) return 2'b01;
    s = s - 2;
    if (s >= body) begin
      s = s - body;
      if (s == 0) return 2'b01;
      if (s == 1) return 2'b11;
      return 2'b10;
    end
    b = s / 36;
    r = s % 36;
    q = r % 4;
    scl = (q == 1) || (q == 2);
    if (r >= 32) oe = 1'b0;
    else oe = ~fr[23 - (b * 8 + r / 4)];
    return {scl, oe};
  endfunction

  always @(posedge clk) begin
    logic was_idle;
    if (reset) begin
      m_in_frame = 1'b0;
      m_pending  = 1'b0;
      m_cyc      = 0;
      m_ack_err  = 1'b0;
      m_nack     = 3;
      exp_q.delete();
    end else begin
      was_idle = !m_in_frame;
      if (m_in_frame) begin
        m_cyc++;
        if (m_cyc == m_len * D) begin
          m_in_frame = 1'b0;
          m_ack_err  = (m_nack < 3);
        end
      end else if (m_pending) begin
        m_frame = {8'h34, 8'h05, 1'b0, m_vol};
        m_nack  = nack_sel;
        m_nb    = (m_nack < 3) ? m_nack + 1 : 3;
        m_len   = 5 + 36 * m_nb;
        for (int i = 0; i < m_nb; i++) exp_q.push_back(m_frame[23 - 8 * i -: 8]);
        m_cyc      = 0;
        m_in_frame = 1'b1;
      end
      if (volchange) begin
        m_pending = 1'b1;
        m_vol     = volume2DAC;
      end else if (was_idle) begin
        m_pending = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [2:0] e;
    if (chk_en) begin
      if (m_in_frame) e = {exp_lines(m_cyc / D, m_frame, m_nb), 1'b1};
      else e = 3'b100;
      chk("lines_scl_oe_busy", {29'd0, i2c_sclk, sdat_oe, busy}, {29'd0, e});
      if (!m_in_frame) chk("ack_error_idle", {31'd0, ack_error}, {31'd0, m_ack_err});
    end
  end

  // I2C slave / bus monitor working from pin levels only.
  logic       slave_low = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       in_xfer = 1'b0;
  int         bitn = 0;
  int         byte_idx = 0;
  logic [7:0] sh = 8'd0;

  assign sdat_in = ~(sdat_oe | slave_low);

  always @(negedge clk) begin
    logic scl, sda;
    scl = i2c_sclk;
    sda = ~(sdat_oe | slave_low);
    if (reset) begin
      in_xfer   = 1'b0;
      bitn      = 0;
      slave_low = 1'b0;
      got_q.delete();
    end else if (prev_scl && scl && prev_sda && !sda) begin
      in_xfer  = 1'b1;
      bitn     = 0;
      byte_idx = 0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      in_xfer = 1'b0;
    end else if (in_xfer && !prev_scl && scl) begin
      if (bitn < 8) begin
        sh = {sh[6:0], sda};
        bitn++;
        if (bitn == 8) got_q.push_back(sh);
      end else begin
        bitn = 0;
        byte_idx++;
      end
    end else if (in_xfer && prev_scl && !scl) begin
      slave_low = (bitn == 8) && (byte_idx != m_nack);
    end
    prev_scl = scl;
    prev_sda = ~(sdat_oe | slave_low);
  end

  task automatic pulse(input logic [6:0] v);
    volume2DAC = v;
    volchange  = 1'b1;
    @(negedge clk);
    volchange  = 1'b0;
  endtask

  task automatic wait_busy(input logic v, input string name);
    int n = 0;
    while (busy !== v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, busy}, {31'd0, v});
  endtask

  task automatic wait_quiet(input string name);
    int q = 0;
    int n = 0;
    while (q < 3 && n < 5000) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0 && !m_in_frame && !m_pending) q++;
      else q = 0;
    end
    chk({name, "_quiet"}, (q >= 3) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_slot(input int slot, input string name);
    int n = 0;
    while (!(m_in_frame && m_cyc >= slot * D) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, m_in_frame ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic drain_check(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic measure_busy(input string name, input int exp_cycles);
    int cnt = 0;
    wait_busy(1'b1, {name, "_rise"});
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    chk({name, "_len"}, cnt, exp_cycles);
  endtask

  initial begin
    int toggles;
    logic prev;
    int n;
    reset      = 1'b1;
    volchange  = 1'b0;
    volume2DAC = 7'd0;

    // 1: reset held, then idle bus for 1000 cycles
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("t1_sclk", {31'd0, i2c_sclk}, 32'd1);
    chk("t1_oe", {31'd0, sdat_oe}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_ack_error", {31'd0, ack_error}, 32'd0);
    reset = 1'b0;
    toggles = 0;
    prev = i2c_sclk;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i2c_sclk !== prev) toggles++;
      prev = i2c_sclk;
    end
    chk("t1_scl_toggles", toggles, 0);

    // 2: single acknowledged write
    nack_sel = 3;
    pulse(7'h79);
    measure_busy("t2_busy", 113 * D);
    wait_quiet("t2");
    chk("t2_nbytes", got_q.size(), 3);
    chk("t2_b0", {24'd0, got_q[0]}, 32'h34);
    chk("t2_b1", {24'd0, got_q[1]}, 32'h05);
    chk("t2_b2", {24'd0, got_q[2]}, 32'h79);
    chk("t2_ack_error", {31'd0, ack_error}, 32'd0);
    drain_check("t2");

    // 3: coalescing during byte 2
    pulse(7'h30);
    wait_slot(45, "t3_in_byte2");
    pulse(7'h40);
    repeat (3) @(negedge clk);
    pulse(7'h50);
    wait_quiet("t3");
    chk("t3_nbytes", got_q.size(), 6);
    chk("t3_data0", {24'd0, got_q[2]}, 32'h30);
    chk("t3_data1", {24'd0, got_q[5]}, 32'h50);
    drain_check("t3");

    // 4: NACK on address byte, then recovery
    nack_sel = 0;
    pulse(7'h22);
    measure_busy("t4_busy", 41 * D);
    wait_quiet("t4a");
    chk("t4_ack_error_set", {31'd0, ack_error}, 32'd1);
    chk("t4_nbytes", got_q.size(), 1);
    chk("t4_b0", {24'd0, got_q[0]}, 32'h34);
    drain_check("t4a");
    nack_sel = 3;
    pulse(7'h60);
    wait_quiet("t4b");
    chk("t4_ack_error_clr", {31'd0, ack_error}, 32'd0);
    chk("t4_data", {24'd0, got_q[2]}, 32'h60);
    drain_check("t4b");

    // 5: reset in the middle of byte 2 with a request pending
    pulse(7'h44);
    wait_slot(50, "t5_in_byte2");
    pulse(7'h55);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_sclk", {31'd0, i2c_sclk}, 32'd1);
    chk("t5_oe", {31'd0, sdat_oe}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_pending", {31'd0, busy}, 32'd0);
    got_q.delete();
    exp_q.delete();
    pulse(7'h2F);
    wait_quiet("t5");
    chk("t5_nbytes", got_q.size(), 3);
    chk("t5_data", {24'd0, got_q[2]}, 32'h2F);
    drain_check("t5");

    // 6: requests right at the end of a frame
    pulse(7'h0A);
    n = 0;
    while (!(m_in_frame && m_cyc == m_len * D - 1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_last_cycle", m_in_frame ? 32'd1 : 32'd0, 32'd1);
    pulse(7'h6B);
    wait_busy(1'b1, "t6_second_rise");
    wait_busy(1'b0, "t6_second_fall");
    pulse(7'h1C);
    wait_quiet("t6");
    chk("t6_nbytes", got_q.size(), 9);
    chk("t6_data0", {24'd0, got_q[2]}, 32'h0A);
    chk("t6_data1", {24'd0, got_q[5]}, 32'h6B);
    chk("t6_data2", {24'd0, got_q[8]}, 32'h1C);
    drain_check("t6");

    // Randomised requests with occasional NACKs
    for (int it = 0; it < 40; it++) begin
      nack_sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3;
      repeat ($urandom_range(1, 500)) @(negedge clk);
      pulse(7'($urandom_range(0, 127)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        pulse(7'($urandom_range(0, 127)));
      end
    end
    wait_quiet("rand");
    drain_check("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
